// File: rtl/axis_i2c_cmd.sv
// AXI-Stream command front end for i2c_fsm: buffers {addr,data} beats in a FIFO
// and issues them one at a time on the start/ready handshake, retrying unacked starts.
module axis_i2c_cmd #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic                             start,
  output logic [ADDR_WIDTH-1:0]            addr,
  output logic [DATA_WIDTH-1:0]            data,
  input  logic                             i2c_ready,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH):0]      level,
  output logic [15:0]                      done_cnt
);

  localparam int unsigned TDW       = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;
  localparam int unsigned ACK_TRIES = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [TDW-1:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_tready;
  logic                 r_start;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]          r_done_cnt;
  logic [1:0]           r_ack_cnt;

  logic                 w_push;
  logic                 w_pop;
  logic [LVL_W-1:0]     w_level_nxt;
  logic [TDW-1:0]       w_head;

  assign w_push      = s_axis_tvalid & r_tready;
  assign w_pop       = (r_state == IDLE) && (r_level != '0) && i2c_ready;
  assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_head      = r_mem[r_rd_ptr];

  // FIFO storage needs no reset; occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_tready   <= 1'b1;
      r_start    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_done_cnt <= '0;
      r_ack_cnt  <= '0;
    end else begin
      r_start  <= 1'b0;
      r_level  <= w_level_nxt;
      r_tready <= (w_level_nxt != LVL_W'(FIFO_DEPTH));
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_addr  <= w_head[TDW-1:DATA_WIDTH];
            r_data  <= w_head[DATA_WIDTH-1:0];
            r_state <= START;
          end
        end
        START: begin
          r_start   <= 1'b1;
          r_ack_cnt <= '0;
          r_state   <= WAIT_ACK;
        end
        // ready still high after ACK_TRIES cycles means the start was missed; retry
        WAIT_ACK: begin
          if (!i2c_ready) begin
            r_state <= WAIT_DONE;
          end else if (r_ack_cnt == 2'(ACK_TRIES - 1)) begin
            r_state <= START;
          end else begin
            r_ack_cnt <= r_ack_cnt + 2'(1);
          end
        end
        WAIT_DONE: begin
          if (i2c_ready) begin
            r_done_cnt <= r_done_cnt + 16'(1);
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign start         = r_start;
  assign addr          = r_addr;
  assign data          = r_data;
  assign level         = r_level;
  assign done_cnt      = r_done_cnt;
  assign busy          = (r_state != IDLE) || (r_level != '0);

endmodule
